game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level game-flow FSM for the Tetris datapath: spawns pieces, times gravity, locks pieces,
//  clears completed rows one at a time, detects overflow, and keeps score, lines and level.
//  Runs on the ~60 Hz frame clock. Emits one-cycle command pulses that the board datapath
//  acts on in the same frame. Derives its own fall tick from level, so no separate fall clock exists.
// PARAMETERS
//  FALL_BASE  30  frames per gravity step at level 0
//  FALL_STEP   2  frames removed from the period per level
//  FALL_MIN    3  floor on the gravity period (frames)
//  MAX_LEVEL  15  level saturation value (must fit in 4 bits)
// PORTS
//  clock               in   1   frame clock (~60 Hz); all logic posedge
//  resetn              in   1   asynchronous active-low reset
//  start_game          in   1   level-sensitive; starts a game from IDLE
//  filled_under        in   1   active piece blocked below (floor or settled cell)
//  overflow            in   1   any settled cell in rows 20..22
//  completed_lines     in   20  bit r = row r full
//  key_down            in   1   soft-drop request (present only with TETRIS_SOFT_DROP_EN)
//  load_block          out  1   pulse: spawn new piece
//  drop_block          out  1   pulse: move piece down one row
//  update_board_state  out  1   pulse: write piece cells into board
//  shift_down          out  1   pulse: delete row clear_index, shift rows above down
//  clear_index         out  5   row to delete; valid while shift_down=1
//  game_over           out  1   high in OVER state
//  level               out  4   current level, 0..MAX_LEVEL
//  lines_total         out  10  rows cleared this game, saturates at 999
//  score               out  20  score, saturates at 20'hFFFFF
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all pulses 0; clear_index=0; game_over=0;
//   level=0; lines_total=0; score=0; fall counter=0; run counter=0.
//  States and transitions:
//  - IDLE: start_game=1 clears score/lines/level/mod-10 counter, then goes to LOAD.
//  - LOAD: load_block=1 for exactly 1 cycle; fall counter:=0; then FALL.
//  - FALL: fall counter increments each cycle. Tick fires when counter == period-1;
//    the counter wraps to 0 on the tick.
//    On tick with !filled_under: drop_block=1 for 1 cycle, stay in FALL.
//    On tick with filled_under: go to LOCK, with no drop pulse.
//  - LOCK: update_board_state=1 for 1 cycle; run counter:=0; then SETTLE.
//  - SETTLE: a 1-cycle wait in which the board register updates.
//    overflow=1 goes to OVER (checked first).
//    Otherwise |completed_lines goes to CLEAR.
//    Otherwise: award points for the run counter, then go to LOAD.
//  - CLEAR: shift_down=1 for 1 cycle; clear_index = lowest set bit of completed_lines;
//    run counter +1 (saturates at 4); then SETTLE.
//  - OVER: game_over=1; sticky until resetn. start_game is ignored.
//  Gravity period, computed in SETTLE->LOAD registers for use by the next piece:
//    period = max(FALL_MIN, FALL_BASE - FALL_STEP*level).
//    Signed arithmetic throughout; never underflows.
//  Scoring, applied once per piece on the SETTLE->LOAD edge when run>0:
//    base 40/100/300/1200 for run 1/2/3/4, multiplied by (level+1).
//    Added to score with saturation at 20'hFFFFF.
//    lines_total += run, saturating at 999.
//    A mod-10 counter increments level (saturating at MAX_LEVEL) on each wrap;
//    level uses the pre-award value for that award's multiplier.
//  Exactly one command pulse may be high in any cycle. start_game outside IDLE is ignored.
//  Rows are cleared lowest-first, one per CLEAR/SETTLE pair (2 cycles per row).
//  Four rows therefore take 8 cycles after LOCK.
// CONFIGURATION
//  TETRIS_SOFT_DROP_EN defined:
//   - key_down port exists.
//   - While key_down=1 in FALL, the effective period is min(period, 2).
//   - Each drop_block issued with key_down=1 adds 1 to score (saturating).
//  TETRIS_SOFT_DROP_EN undefined: no key_down port; gravity uses period only.
// TESTING
//  1 Reset: resetn=0 mid-FALL -> next cycle state IDLE, all outputs 0, score/level/lines 0.
//  2 start_game=1, filled_under=0 -> load_block 1 cycle later; first drop_block 30 frames after
//    LOAD; subsequent drops every 30 frames.
//  3 filled_under=1 at tick, completed_lines=0x00003 (clear after each shift)
//    -> update_board_state, then shift_down idx 0, then shift_down idx 0 again, then load_block;
//    score=100, lines_total=2.
//  4 Ten single-row clears at level 0 -> level=1, score=400, next period 28 frames;
//    at level 14, period=3 (floor).
//  5 overflow=1 in SETTLE with completed_lines!=0 -> OVER (overflow wins); game_over=1 held;
//    start_game pulses ignored.
//  6 [TETRIS_SOFT_DROP_EN] key_down=1 at level 0 -> drop_block every 2 frames, score +1 per drop.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow FSM for the Tetris datapath. It spawns pieces, times gravity from
// the current level, locks pieces, clears completed rows lowest-first, detects overflow, and
// keeps score, lines and level. It runs on the frame clock. Command pulses are registered and
// last one frame.
//
// Optional feature: define TETRIS_SOFT_DROP_EN to add key_down_i. Holding key_down_i in FALL
// caps the gravity period at 2 frames, and each drop issued with it held scores +1.
//
// Ports:
//   clock_i             frame clock, posedge
//   resetn_i            asynchronous active-low reset
//   start_game_i        starts a game from IDLE (level-sensitive)
//   filled_under_i      active piece is blocked below
//   overflow_i          a settled cell exists in rows 20..22
//   completed_lines_i   bit r set = row r is full
//   key_down_i          soft-drop request (TETRIS_SOFT_DROP_EN only)
//   load_block_o        pulse: spawn a new piece
//   drop_block_o        pulse: move the piece down one row
//   update_board_state_o pulse: write the piece cells into the board
//   shift_down_o        pulse: delete row clear_index_o and shift the rows above down
//   clear_index_o       row to delete; valid while shift_down_o is high
//   game_over_o         high in OVER
//   level_o             current level
//   lines_total_o       rows cleared this game, saturates at 999
//   score_o             score, saturates at 20'hFFFFF
module game_sequencer #(
  parameter int FALL_BASE = 30,  // must fit in 5 bits
  parameter int FALL_STEP = 2,
  parameter int FALL_MIN  = 3,
  parameter int MAX_LEVEL = 15
) (
  input  logic        clock_i,
  input  logic        resetn_i,
  input  logic        start_game_i,
  input  logic        filled_under_i,
  input  logic        overflow_i,
  input  logic [19:0] completed_lines_i,
`ifdef TETRIS_SOFT_DROP_EN
  input  logic        key_down_i,
`endif
  output logic        load_block_o,
  output logic        drop_block_o,
  output logic        update_board_state_o,
  output logic        shift_down_o,
  output logic [4:0]  clear_index_o,
  output logic        game_over_o,
  output logic [3:0]  level_o,
  output logic [9:0]  lines_total_o,
  output logic [19:0] score_o
);

  localparam logic [3:0]  MaxLevel = 4'(MAX_LEVEL);
  localparam logic [19:0] ScoreMax = 20'hFFFFF;
  localparam logic [9:0]  LinesMax = 10'd999;

  typedef enum logic [2:0] {
    StIdle, StLoad, StFall, StLock, StSettle, StClear, StOver
  } state_e;

  state_e      state_q;
  logic [4:0]  fall_cnt_q;
  logic [4:0]  period_q;
  logic [2:0]  run_q;
  logic [3:0]  mod10_q;
  logic [3:0]  level_q;
  logic [9:0]  lines_q;
  logic [19:0] score_q;
  logic        load_block_q;
  logic        drop_block_q;
  logic        update_board_q;
  logic        shift_down_q;
  logic        game_over_q;
  logic [4:0]  clear_index_q;

  // Gravity period for a level, clamped at FALL_MIN; signed so it cannot wrap.
  function automatic logic [4:0] calc_period(input logic [3:0] lvl);
    int p;
    p = FALL_BASE - FALL_STEP * int'(lvl);
    if (p < FALL_MIN) p = FALL_MIN;
    return 5'(p);
  endfunction

  logic [4:0]  eff_period;
  logic        tick;
  logic [4:0]  low_idx;
  logic [10:0] base_pts;
  logic [15:0] pts;
  logic [20:0] score_sum;
  logic [19:0] score_award;
  logic [10:0] lines_sum;
  logic [9:0]  lines_award;
  logic [4:0]  mod_sum;
  logic        mod_wrap;
  logic [3:0]  mod_award;
  logic [3:0]  level_award;
`ifdef TETRIS_SOFT_DROP_EN
  logic [19:0] score_inc;
`endif

  always_comb begin
    eff_period = period_q;
`ifdef TETRIS_SOFT_DROP_EN
    if (key_down_i && (period_q > 5'd2)) eff_period = 5'd2;
`endif
    // >= rather than == so a shortened period takes effect even if the count is already past it.
    tick = (fall_cnt_q >= (eff_period - 5'd1));
  end

  // Lowest full row wins.
  always_comb begin
    low_idx = '0;
    for (int r = 19; r >= 0; r--) begin
      if (completed_lines_i[r]) low_idx = 5'(r);
    end
  end

  // Award for the finished piece. A run of 0 leaves every value unchanged.
  always_comb begin
    case (run_q)
      3'd1:    base_pts = 11'd40;
      3'd2:    base_pts = 11'd100;
      3'd3:    base_pts = 11'd300;
      3'd4:    base_pts = 11'd1200;
      default: base_pts = 11'd0;
    endcase
    // Multiplier uses the level before this award.
    pts         = 16'(base_pts) * 16'({1'b0, level_q} + 5'd1);
    score_sum   = {1'b0, score_q} + {5'd0, pts};
    score_award = score_sum[20] ? ScoreMax : score_sum[19:0];
    lines_sum   = {1'b0, lines_q} + {8'd0, run_q};
    lines_award = (lines_sum > 11'd999) ? LinesMax : lines_sum[9:0];
    // run <= 4, so at most one wrap per award.
    mod_sum     = {1'b0, mod10_q} + {2'd0, run_q};
    mod_wrap    = (mod_sum >= 5'd10);
    mod_award   = mod_wrap ? 4'(mod_sum - 5'd10) : mod_sum[3:0];
    level_award = (mod_wrap && (level_q < MaxLevel)) ? level_q + 4'd1 : level_q;
  end

`ifdef TETRIS_SOFT_DROP_EN
  assign score_inc = (score_q == ScoreMax) ? ScoreMax : score_q + 20'd1;
`endif

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q        <= StIdle;
      fall_cnt_q     <= '0;
      period_q       <= calc_period(4'd0);
      run_q          <= '0;
      mod10_q        <= '0;
      level_q        <= '0;
      lines_q        <= '0;
      score_q        <= '0;
      load_block_q   <= 1'b0;
      drop_block_q   <= 1'b0;
      update_board_q <= 1'b0;
      shift_down_q   <= 1'b0;
      game_over_q    <= 1'b0;
      clear_index_q  <= '0;
    end else begin
      load_block_q   <= 1'b0;
      drop_block_q   <= 1'b0;
      update_board_q <= 1'b0;
      shift_down_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_game_i) begin
            score_q      <= '0;
            lines_q      <= '0;
            level_q      <= '0;
            mod10_q      <= '0;
            run_q        <= '0;
            period_q     <= calc_period(4'd0);
            fall_cnt_q   <= '0;
            load_block_q <= 1'b1;
            state_q      <= StLoad;
          end
        end
        StLoad: begin
          // The LOAD frame counts toward the first gravity step, so the first drop lands
          // exactly one period after the load pulse.
          fall_cnt_q <= 5'd1;
          state_q    <= StFall;
        end
        StFall: begin
          if (tick) begin
            fall_cnt_q <= '0;
            if (filled_under_i) begin
              update_board_q <= 1'b1;
              run_q          <= '0;
              state_q        <= StLock;
            end else begin
              drop_block_q <= 1'b1;
`ifdef TETRIS_SOFT_DROP_EN
              if (key_down_i) score_q <= score_inc;
`endif
            end
          end else begin
            fall_cnt_q <= fall_cnt_q + 5'd1;
          end
        end
        StLock: state_q <= StSettle;
        StSettle: begin
          if (overflow_i) begin
            game_over_q <= 1'b1;
            state_q     <= StOver;
          end else if (|completed_lines_i) begin
            shift_down_q  <= 1'b1;
            clear_index_q <= low_idx;
            run_q         <= (run_q == 3'd4) ? 3'd4 : run_q + 3'd1;
            state_q       <= StClear;
          end else begin
            score_q      <= score_award;
            lines_q      <= lines_award;
            mod10_q      <= mod_award;
            level_q      <= level_award;
            period_q     <= calc_period(level_award);
            fall_cnt_q   <= '0;
            load_block_q <= 1'b1;
            state_q      <= StLoad;
          end
        end
        StClear: state_q <= StSettle;
        StOver:  state_q <= StOver;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign load_block_o         = load_block_q;
  assign drop_block_o         = drop_block_q;
  assign update_board_state_o = update_board_q;
  assign shift_down_o         = shift_down_q;
  assign clear_index_o        = clear_index_q;
  assign game_over_o          = game_over_q;
  assign level_o              = level_q;
  assign lines_total_o        = lines_q;
  assign score_o              = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
`timescale 1ns/1ps
module tb_game_sequencer;

  localparam int KLoad  = 1;
  localparam int KDrop  = 2;
  localparam int KUbs   = 3;
  localparam int KShift = 4;

  typedef struct {
    int kind;
    int idx;
    int cyc;
    bit stat;
    int sc;
    int ln;
    int lv;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_game = 1'b0;
  logic        filled_under = 1'b0;
  logic        overflow = 1'b0;
  logic [19:0] completed_lines = '0;
`ifdef TETRIS_SOFT_DROP_EN
  logic        key_down = 1'b0;
`endif
  logic        load_block, drop_block, update_board_state, shift_down, game_over;
  logic [4:0]  clear_index;
  logic [3:0]  level;
  logic [9:0]  lines_total;
  logic [19:0] score;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];

  game_sequencer dut (
    .clock_i              (clk),
    .resetn_i             (resetn),
    .start_game_i         (start_game),
    .filled_under_i       (filled_under),
    .overflow_i           (overflow),
    .completed_lines_i    (completed_lines),
`ifdef TETRIS_SOFT_DROP_EN
    .key_down_i           (key_down),
`endif
    .load_block_o         (load_block),
    .drop_block_o         (drop_block),
    .update_board_state_o (update_board_state),
    .shift_down_o         (shift_down),
    .clear_index_o        (clear_index),
    .game_over_o          (game_over),
    .level_o              (level),
    .lines_total_o        (lines_total),
    .score_o              (score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int idx, input int c, input bit stat,
                      input int sc, input int ln, input int lv);
    exp_t e;
    e.kind = kind; e.idx = idx; e.cyc = c; e.stat = stat; e.sc = sc; e.ln = ln; e.lv = lv;
    expq.push_back(e);
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_idle(input string pre);
    chk({pre, "_load"}, load_block, 0);
    chk({pre, "_drop"}, drop_block, 0);
    chk({pre, "_ubs"}, update_board_state, 0);
    chk({pre, "_shift"}, shift_down, 0);
    chk({pre, "_clear_index"}, clear_index, 0);
    chk({pre, "_game_over"}, game_over, 0);
    chk({pre, "_level"}, level, 0);
    chk({pre, "_lines"}, lines_total, 0);
    chk({pre, "_score"}, score, 0);
  endtask

  function automatic int period_of(input int lv);
    int p;
    p = 30 - 2 * lv;
    if (p < 3) p = 3;
    return p;
  endfunction

  // Monitor: every command pulse is matched against the next expected event.
  always @(negedge clk) begin
    int   n;
    int   k;
    exp_t e;
    n = int'(load_block) + int'(drop_block) + int'(update_board_state) + int'(shift_down);
    if (n != 0) begin
      chk("pulse_onehot", n, 1);
      k = load_block ? KLoad : drop_block ? KDrop : update_board_state ? KUbs : KShift;
      if (expq.size() == 0) begin
        chk("unexpected_pulse_kind", k, 0);
      end else begin
        e = expq.pop_front();
        chk("pulse_kind", k, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        if (e.kind == KShift) chk("clear_index", clear_index, e.idx);
        if (e.stat) begin
          chk("score", score, e.sc);
          chk("lines_total", lines_total, e.ln);
          chk("level", level, e.lv);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int L;
    int p;
    int r;
    int sc;
    int ln;
    int lv;

    repeat (3) @(negedge clk);
    check_idle("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Start, then two gravity drops 30 frames apart.
    s = cyc;
    push(KLoad, 0, s + 1, 1, 0, 0, 0);
    push(KDrop, 0, s + 31, 0, 0, 0, 0);
    push(KDrop, 0, s + 61, 0, 0, 0, 0);
    start_game = 1'b1;
    @(negedge clk);
    start_game = 1'b0;

    // Lock with rows 0 and 1 full: two shifts of row 0, then 100 points.
    at(s + 62);
    filled_under = 1'b1;
    push(KUbs, 0, s + 91, 0, 0, 0, 0);
    push(KShift, 0, s + 93, 0, 0, 0, 0);
    push(KShift, 0, s + 95, 0, 0, 0, 0);
    push(KLoad, 0, s + 97, 1, 100, 2, 0);
    at(s + 91);
    filled_under = 1'b0;
    completed_lines = 20'h00003;
    at(s + 93);
    completed_lines = 20'h00001;
    at(s + 95);
    completed_lines = 20'h00000;

    // Reset in the middle of FALL.
    at(s + 110);
    resetn = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_fall");
    resetn = 1'b1;
    @(negedge clk);

    // New game: ten single-row clears at level 0.
    s = cyc;
    push(KLoad, 0, s + 1, 1, 0, 0, 0);
    start_game = 1'b1;
    @(negedge clk);
    start_game = 1'b0;
    L = s + 1;
    sc = 0;
    ln = 0;
    lv = 0;
    for (int i = 0; i < 10; i++) begin
      r = (i * 3) % 20;
      at(L);
      filled_under = 1'b1;
      sc = sc + 40;
      ln = ln + 1;
      lv = (i == 9) ? 1 : 0;
      push(KUbs, 0, L + 30, 0, 0, 0, 0);
      push(KShift, r, L + 32, 0, 0, 0, 0);
      push(KLoad, 0, L + 34, 1, sc, ln, lv);
      at(L + 30);
      filled_under = 1'b0;
      completed_lines = 20'd1 << r;
      at(L + 32);
      completed_lines = '0;
      L = L + 34;
    end

    // Level 1: period 28, then a lock that clears nothing.
    at(L);
    push(KDrop, 0, L + 28, 0, 0, 0, 0);
    push(KDrop, 0, L + 56, 0, 0, 0, 0);
    push(KUbs, 0, L + 84, 0, 0, 0, 0);
    push(KLoad, 0, L + 86, 1, 400, 10, 1);
    at(L + 57);
    filled_under = 1'b1;
    at(L + 84);
    filled_under = 1'b0;
    L = L + 86;

    // Four-row clears until level 14.
    while (ln < 140) begin
      p = period_of(lv);
      at(L);
      filled_under = 1'b1;
      sc = sc + 1200 * (lv + 1);
      ln = ln + 4;
      lv = (ln / 10 > 15) ? 15 : ln / 10;
      push(KUbs, 0, L + p, 0, 0, 0, 0);
      push(KShift, 5, L + p + 2, 0, 0, 0, 0);
      push(KShift, 5, L + p + 4, 0, 0, 0, 0);
      push(KShift, 5, L + p + 6, 0, 0, 0, 0);
      push(KShift, 5, L + p + 8, 0, 0, 0, 0);
      push(KLoad, 0, L + p + 10, 1, sc, ln, lv);
      at(L + p);
      filled_under = 1'b0;
      completed_lines = 20'h001E0;
      at(L + p + 2);
      completed_lines = 20'h000E0;
      at(L + p + 4);
      completed_lines = 20'h00060;
      at(L + p + 6);
      completed_lines = 20'h00020;
      at(L + p + 8);
      completed_lines = 20'h00000;
      L = L + p + 10;
    end

    // Level 14: period floors at 3; then overflow wins over a full row.
    at(L);
    push(KDrop, 0, L + 3, 0, 0, 0, 0);
    push(KDrop, 0, L + 6, 0, 0, 0, 0);
    push(KUbs, 0, L + 9, 0, 0, 0, 0);
    at(L + 6);
    filled_under = 1'b1;
    at(L + 9);
    filled_under = 1'b0;
    overflow = 1'b1;
    completed_lines = 20'h00001;
    at(L + 11);
    chk("game_over", game_over, 1);
    chk("over_level", level, 14);
    chk("over_score", score, sc);
    for (int i = 0; i < 3; i++) begin
      start_game = 1'b1;
      repeat (2) @(negedge clk);
      start_game = 1'b0;
      @(negedge clk);
      chk("over_sticky", game_over, 1);
    end
    overflow = 1'b0;
    completed_lines = '0;
    repeat (5) @(negedge clk);
    chk("over_hold", game_over, 1);
    chk("over_lines", lines_total, ln);

`ifdef TETRIS_SOFT_DROP_EN
    // Soft drop at level 0: a drop every 2 frames, +1 each.
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    s = cyc;
    key_down = 1'b1;
    push(KLoad, 0, s + 1, 1, 0, 0, 0);
    push(KDrop, 0, s + 3, 1, 1, 0, 0);
    push(KDrop, 0, s + 5, 1, 2, 0, 0);
    push(KDrop, 0, s + 7, 1, 3, 0, 0);
    start_game = 1'b1;
    @(negedge clk);
    start_game = 1'b0;
    at(s + 7);
    key_down = 1'b0;
`endif

    repeat (10) @(negedge clk);
    chk("events_pending", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
